// File: rtl/pn_seq_gen.sv
// pn_seq_gen: parametrised Galois-LFSR pseudo-noise generator.
// Emits the serial PN bit, the raw LFSR state, and OUT_W-bit packed words
// (first generated bit in the MSB) through a valid/ready handshake.
// The LFSR stalls rather than drop or overwrite an unread word.
// A runtime seed can be loaded. A zero seed is replaced by SEED and flagged.
module pn_seq_gen #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  POLY  = WIDTH'(8'h71),
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(8'h01),
  parameter int                OUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_in,
  output logic              bit_out,
  output logic [WIDTH-1:0]  state_out,
  output logic [OUT_W-1:0]  word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              wrap,
  output logic              seed_err
);

  // Bits-in-word counter width; a 1-bit word still needs a legal vector.
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
  // The pack register only needs the bits that precede the completing bit.
  localparam int PACK_W = (OUT_W > 1) ? OUT_W - 1 : 1;

  logic [WIDTH-1:0]  lfsr_reg;
  logic [WIDTH-1:0]  lfsr_next;
  logic [WIDTH-1:0]  seed_reg;
  logic [WIDTH-1:0]  load_value;
  logic [CNT_W-1:0]  cnt_reg;
  logic [PACK_W-1:0] pack_reg;
  logic [OUT_W-1:0]  pack_next;
  logic [OUT_W-1:0]  word_data_reg;
  logic              word_valid_reg;
  logic              wrap_reg;
  logic              seed_err_reg;

  logic msb;
  logic last_bit;
  logic stall;
  logic step;
  logic consume;
  logic seed_zero;

  assign msb       = lfsr_reg[WIDTH-1];
  assign last_bit  = (cnt_reg == CNT_LAST);
  // Hold the LFSR when the word about to complete has nowhere to go.
  assign stall     = en & word_valid_reg & ~word_ready & last_bit;
  assign step      = en & ~stall & ~seed_load;
  assign consume   = word_valid_reg & word_ready;
  assign seed_zero = (seed_in == '0);
  assign load_value = seed_zero ? SEED : seed_in;

  // Galois step: shift left.
  // Each tap bit is XORed with the outgoing MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lfsr
      if (gi == 0) begin : g_lsb
        assign lfsr_next[gi] = msb & POLY[gi];
      end else begin : g_upper
        assign lfsr_next[gi] = lfsr_reg[gi-1] ^ (msb & POLY[gi]);
      end
    end
  endgenerate

  // Packed word including the bit generated this step.
  // The new bit enters at the LSB.
  generate
    if (OUT_W == 1) begin : g_pack_single
      assign pack_next = msb;
    end else begin : g_pack_multi
      for (gi = 0; gi < OUT_W; gi++) begin : g_pack
        if (gi == 0) begin : g_first
          assign pack_next[gi] = msb;
        end else begin : g_rest
          assign pack_next[gi] = pack_reg[gi-1];
        end
      end
    end
  endgenerate

  // LFSR, seed, packing counter, output word handshake and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_reg       <= SEED;
      seed_reg       <= SEED;
      cnt_reg        <= '0;
      pack_reg       <= '0;
      word_data_reg  <= '0;
      word_valid_reg <= 1'b0;
      wrap_reg       <= 1'b0;
      seed_err_reg   <= 1'b0;
    end else begin
      wrap_reg     <= 1'b0;
      seed_err_reg <= 1'b0;
      if (seed_load) begin
        // A seed load restarts word assembly and discards any pending word.
        lfsr_reg       <= load_value;
        seed_reg       <= load_value;
        cnt_reg        <= '0;
        pack_reg       <= '0;
        word_valid_reg <= 1'b0;
        seed_err_reg   <= seed_zero;
      end else begin
        if (consume) begin
          word_valid_reg <= 1'b0;
        end
        if (step) begin
          lfsr_reg <= lfsr_next;
          wrap_reg <= (lfsr_next == seed_reg);
          if (last_bit) begin
            // A completing word overrides the consume-clear.
            // Stall guarantees the old word was either taken or absent.
            word_data_reg  <= pack_next;
            word_valid_reg <= 1'b1;
            cnt_reg        <= '0;
            pack_reg       <= '0;
          end else begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
            pack_reg <= pack_next[PACK_W-1:0];
          end
        end
      end
    end
  end

  assign bit_out    = msb;
  assign state_out  = lfsr_reg;
  assign word_data  = word_data_reg;
  assign word_valid = word_valid_reg;
  assign wrap       = wrap_reg;
  assign seed_err   = seed_err_reg;

endmodule

// File: tb/tb_pn_seq_gen.sv
// tb_pn_seq_gen: randomized and directed bench for pn_seq_gen (default parameters).
// A queue-based behavioural model predicts every output each cycle.
// Directed sections pin the model with hand-computed values.
module tb_pn_seq_gen;

  localparam int          W      = 8;
  localparam int          OW     = 8;
  localparam int unsigned POLY_I = 32'h71;
  localparam int unsigned SEED_I = 32'h01;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          word_ready = 1'b0;
  logic          bit_out;
  logic [W-1:0]  state_out;
  logic [OW-1:0] word_data;
  logic          word_valid;
  logic          wrap;
  logic          seed_err;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  pn_seq_gen #(
    .WIDTH(W),
    .POLY (8'h71),
    .SEED (8'h01),
    .OUT_W(OW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .bit_out   (bit_out),
    .state_out (state_out),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .wrap      (wrap),
    .seed_err  (seed_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned m_state;
  int unsigned m_seed;
  int unsigned m_wdata;
  bit          m_wvalid;
  bit          m_wrap;
  bit          m_serr;
  bit          bitq[$];

  // Multiply by x modulo the feedback polynomial (x^W term implied).
  function automatic int unsigned pn_next(input int unsigned s);
    int unsigned t;
    t = s * 2;
    if (t >= (32'd1 << W)) t = t ^ ((32'd1 << W) | POLY_I);
    return t;
  endfunction

  task automatic model_reset();
    m_state  = SEED_I;
    m_seed   = SEED_I;
    m_wdata  = 0;
    m_wvalid = 1'b0;
    m_wrap   = 1'b0;
    m_serr   = 1'b0;
    bitq.delete();
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit          blocked;
    int unsigned w;
    if (reset) begin
      model_reset();
      return;
    end
    m_wrap = 1'b0;
    m_serr = 1'b0;
    if (seed_load) begin
      m_state  = (seed_in == 0) ? SEED_I : int'(seed_in);
      m_seed   = m_state;
      m_serr   = (seed_in == 0);
      m_wvalid = 1'b0;
      bitq.delete();
      return;
    end
    blocked = en && m_wvalid && !word_ready && (bitq.size() == OW - 1);
    if (m_wvalid && word_ready) m_wvalid = 1'b0;
    if (en && !blocked) begin
      bitq.push_back(bit'((m_state >> (W - 1)) & 1));
      m_state = pn_next(m_state);
      m_wrap  = (m_state == m_seed);
      if (bitq.size() == OW) begin
        w = 0;
        foreach (bitq[i]) w = (w << 1) | int'(bitq[i]);
        m_wdata  = w;
        m_wvalid = 1'b1;
        bitq.delete();
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("bit_out",    32'(bit_out),    (m_state >> (W - 1)) & 1);
      check("state_out",  32'(state_out),  m_state);
      check("word_valid", 32'(word_valid), 32'(m_wvalid));
      check("word_data",  32'(word_data),  m_wdata);
      check("wrap",       32'(wrap),       32'(m_wrap));
      check("seed_err",   32'(seed_err),   32'(m_serr));
    end
  end

  // One clock; returns just after the falling edge so inputs change mid-cycle.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic first_word_seq(input string tag);
    logic [7:0] exp_bits;
    exp_bits = 8'b0000_0001;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_bit"}, 32'(bit_out), 32'(exp_bits[7-k]));
      cyc();
    end
    check({tag, "_state8"}, 32'(state_out), 32'h71);
    check({tag, "_valid"},  32'(word_valid), 32'h1);
    check({tag, "_word"},   32'(word_data), 32'h01);
  endtask

  initial begin
    int wrap_cnt;
    int wrap_at;
    logic [W-1:0] st_at_wrap;

    model_reset();
    chk_on     = 1'b1;
    en         = 1'b1;
    word_ready = 1'b1;
    reset      = 1'b1;
    cyc();
    check("rst_state", 32'(state_out), 32'h01);
    check("rst_valid", 32'(word_valid), 32'h0);
    cyc();
    reset = 1'b0;

    // Default sequence and first word.
    first_word_seq("t1");

    // Full period: exactly one wrap at step 255.
    wrap_cnt = 0; wrap_at = 0; st_at_wrap = '0;
    for (int n = 9; n <= 260; n++) begin
      cyc();
      if (wrap) begin
        wrap_cnt++;
        wrap_at = n;
        st_at_wrap = state_out;
      end
    end
    check("t2_wrap_cnt",   32'(wrap_cnt), 32'd1);
    check("t2_wrap_step",  32'(wrap_at), 32'd255);
    check("t2_wrap_state", 32'(st_at_wrap), 32'h01);

    // Backpressure: 7 more steps after the first word, then stall.
    do_reset();
    word_ready = 1'b0;
    repeat (20) cyc();
    check("t3_stall_state", 32'(state_out), 32'hC1);
    check("t3_stall_word",  32'(word_data), 32'h01);
    check("t3_stall_valid", 32'(word_valid), 32'h1);
    word_ready = 1'b1;
    cyc();
    check("t3_next_word",  32'(word_data), 32'h63);
    check("t3_next_valid", 32'(word_valid), 32'h1);
    check("t3_next_state", 32'(state_out), 32'hF3);

    // Runtime seed mid-word, then a full period from the new seed.
    do_reset();
    repeat (3) cyc();
    seed_load = 1'b1;
    seed_in   = 8'hA5;
    cyc();
    seed_load = 1'b0;
    check("t4_state", 32'(state_out), 32'hA5);
    check("t4_valid", 32'(word_valid), 32'h0);
    wrap_cnt = 0; wrap_at = 0; st_at_wrap = '0;
    for (int n = 1; n <= 300; n++) begin
      cyc();
      if (wrap) begin
        wrap_cnt++;
        wrap_at = n;
        st_at_wrap = state_out;
      end
    end
    check("t4_wrap_cnt",   32'(wrap_cnt), 32'd1);
    check("t4_wrap_step",  32'(wrap_at), 32'd255);
    check("t4_wrap_state", 32'(st_at_wrap), 32'hA5);

    // Zero seed is rejected.
    seed_load = 1'b1;
    seed_in   = 8'h00;
    cyc();
    seed_load = 1'b0;
    check("t5_seed_err", 32'(seed_err), 32'h1);
    check("t5_state",    32'(state_out), 32'h01);
    cyc();
    check("t5_seed_err_clr", 32'(seed_err), 32'h0);

    // Asynchronous reset while a word is pending and the LFSR is stalled.
    word_ready = 1'b0;
    repeat (20) cyc();
    check("t6_pre_valid", 32'(word_valid), 32'h1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_state", 32'(state_out), 32'h01);
    check("t6_valid", 32'(word_valid), 32'h0);
    check("t6_word",  32'(word_data), 32'h00);
    check("t6_bit",   32'(bit_out), 32'h0);
    check("t6_wrap",  32'(wrap), 32'h0);
    cyc();
    cyc();
    reset      = 1'b0;
    word_ready = 1'b1;
    first_word_seq("t6");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (reset) reset = 1'b0;
      en         = ($urandom_range(0, 9) != 0);
      word_ready = ($urandom_range(0, 2) != 0);
      seed_load  = ($urandom_range(0, 149) == 0);
      seed_in    = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      cyc();
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
